// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM states and a parity check helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // xor_all is the XOR of every data bit and the received parity bit.
    function automatic logic parity_error(input int mode, input logic xor_all);
        return (mode == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Power-of-two FIFO for received words; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, mid-bit sampling FSM and an output FIFO carrying error flags.
module uart_rx_cfg #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err_parity,
    output logic                 rd_err_frame,
    output logic                 overrun,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int CYC_COUNT = SYSTEM_CLOCK / BAUD_RATE;
    localparam int CYC_HALF  = CYC_COUNT / 2;
    localparam int CW        = $clog2(CYC_COUNT) + 1;
    localparam int WW        = DATA_BITS + 2;
    localparam logic [CW-1:0] FULL_LAST = CW'(CYC_COUNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYC_HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t         state_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        bit_q;
    logic [DATA_BITS-1:0] data_q;
    logic              perr_q;
    logic              ferr_q;
    logic              push_q;
    logic [WW-1:0]     push_word_q;
    logic              din_s1_q;
    logic              din_s2_q;
    logic              din_prev_q;
    logic [1:0]        flush_q;
    logic              armed_q;
    logic              fall;
    logic              sample;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WW-1:0]     head_word;

    // A falling edge only counts once a genuine high has been seen after reset,
    // so a line held low through reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_s1_q   <= 1'b1;
            din_s2_q   <= 1'b1;
            din_prev_q <= 1'b1;
            flush_q    <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            din_s1_q   <= din;
            din_s2_q   <= din_s1_q;
            din_prev_q <= din_s2_q;
            flush_q    <= {flush_q[0], 1'b1};
            armed_q    <= armed_q | (flush_q[1] & din_s2_q);
        end
    end

    assign fall   = armed_q & din_prev_q & ~din_s2_q;
    assign sample = (cnt_q == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q <= 1'b0;
            cnt_q  <= (state_q == ST_IDLE || sample) ? '0 : cnt_q + CW'(1);
            case (state_q)
                ST_IDLE: begin
                    bit_q <= '0;
                    if (fall) begin
                        state_q <= ST_START;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= din_s2_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        data_q <= {din_s2_q, data_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= '0;
                            state_q <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        perr_q  <= parity_error(PARITY, (^data_q) ^ din_s2_q);
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        if (bit_q == STOP_LAST) begin
                            state_q     <= ST_IDLE;
                            push_q      <= 1'b1;
                            push_word_q <= {ferr_q | ~din_s2_q, perr_q, data_q};
                        end else begin
                            ferr_q <= ferr_q | ~din_s2_q;
                            bit_q  <= bit_q + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_word_q),
        .full_o      (fifo_full),
        .pop_i       (rd_ready),
        .pop_data_o  (head_word),
        .empty_o     (fifo_empty)
    );

    assign rd_valid      = ~fifo_empty;
    assign rd_data       = head_word[DATA_BITS-1:0];
    assign rd_err_parity = head_word[DATA_BITS];
    assign rd_err_frame  = head_word[DATA_BITS+1];
    assign overrun       = push_q & fifo_full & ~(rd_valid & rd_ready);
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver instances (8N1, 8E1, 8O1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int CYC = 16;
    localparam int NI  = 4;

    logic       clk;
    logic       rst;
    logic       din_v        [NI];
    logic       rd_ready_v   [NI];
    logic       rd_valid_w   [NI];
    logic [7:0] rd_data_w    [NI];
    logic       rd_err_par_w [NI];
    logic       rd_err_frm_w [NI];
    logic       overrun_w    [NI];
    logic       busy_w       [NI];

    int vectors;
    int miscompares;
    int ov_cnt   [NI];
    int busy_cnt [NI];
    int rd_ptr;
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cfg #(.SYSTEM_CLOCK(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
        .clk(clk), .rst(rst), .din(din_v[0]), .rd_valid(rd_valid_w[0]), .rd_ready(rd_ready_v[0]),
        .rd_data(rd_data_w[0]), .rd_err_parity(rd_err_par_w[0]), .rd_err_frame(rd_err_frm_w[0]),
        .overrun(overrun_w[0]), .busy(busy_w[0]));
    uart_rx_cfg #(.SYSTEM_CLOCK(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
        .clk(clk), .rst(rst), .din(din_v[1]), .rd_valid(rd_valid_w[1]), .rd_ready(rd_ready_v[1]),
        .rd_data(rd_data_w[1]), .rd_err_parity(rd_err_par_w[1]), .rd_err_frame(rd_err_frm_w[1]),
        .overrun(overrun_w[1]), .busy(busy_w[1]));
    uart_rx_cfg #(.SYSTEM_CLOCK(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
        .clk(clk), .rst(rst), .din(din_v[2]), .rd_valid(rd_valid_w[2]), .rd_ready(rd_ready_v[2]),
        .rd_data(rd_data_w[2]), .rd_err_parity(rd_err_par_w[2]), .rd_err_frame(rd_err_frm_w[2]),
        .overrun(overrun_w[2]), .busy(busy_w[2]));
    uart_rx_cfg #(.SYSTEM_CLOCK(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
        .clk(clk), .rst(rst), .din(din_v[3]), .rd_valid(rd_valid_w[3]), .rd_ready(rd_ready_v[3]),
        .rd_data(rd_data_w[3]), .rd_err_parity(rd_err_par_w[3]), .rd_err_frame(rd_err_frm_w[3]),
        .overrun(overrun_w[3]), .busy(busy_w[3]));

    // Observed words are tagged {instance, frame err, parity err, data}.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst && rd_valid_w[i] && rd_ready_v[i]) begin
                got_q.push_back({i[1:0], rd_err_frm_w[i], rd_err_par_w[i], rd_data_w[i]});
            end
            if (overrun_w[i]) ov_cnt[i]++;
            if (busy_w[i]) busy_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int idx, input logic ferr, input logic perr, input logic [7:0] d);
        return {idx[1:0], ferr, perr, d};
    endfunction

    task automatic drive_bit(input int idx, input logic b);
        din_v[idx] = b;
        repeat (CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input int has_par, input logic pbit,
                              input logic [1:0] stops, input int nstop);
        drive_bit(idx, 1'b0);
        for (int b = 0; b < 8; b++) drive_bit(idx, d[b]);
        if (has_par != 0) drive_bit(idx, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(idx, stops[s]);
        din_v[idx] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic [11:0] exp;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            for (int k = 0; k < 400 && got_q.size() <= rd_ptr; k++) @(negedge clk);
            if (got_q.size() > rd_ptr) begin
                check(tag, 32'(got_q[rd_ptr]), 32'(exp));
                rd_ptr++;
            end else begin
                check({tag, "_missing"}, got_q.size(), rd_ptr + 1);
            end
        end
        #1;
    endtask

    initial begin
        int b0;
        int o0;
        vectors     = 0;
        miscompares = 0;
        rd_ptr      = 0;
        for (int i = 0; i < NI; i++) begin
            din_v[i]      = 1'b1;
            rd_ready_v[i] = 1'b1;
            ov_cnt[i]     = 0;
            busy_cnt[i]   = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rd_valid_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_data", rd_data_w[0], 0);
        check("rst_flags", {rd_err_frm_w[0], rd_err_par_w[0], overrun_w[0]}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        // 8N1 0xA5, clean frame
        send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1);
        exp_q.push_back(mk(0, 1'b0, 1'b0, 8'hA5));
        drain("n1_a5");
        check("n1_idle_busy", busy_w[0], 0);

        // Parity: 0x07 has three ones
        send_frame(1, 8'h07, 1, 1'b0, 2'b11, 1);
        exp_q.push_back(mk(1, 1'b0, 1'b1, 8'h07));
        drain("e1_bad");
        send_frame(1, 8'h07, 1, 1'b1, 2'b11, 1);
        exp_q.push_back(mk(1, 1'b0, 1'b0, 8'h07));
        drain("e1_good");
        send_frame(2, 8'h07, 1, 1'b0, 2'b11, 1);
        exp_q.push_back(mk(2, 1'b0, 1'b0, 8'h07));
        drain("o1_good");
        send_frame(2, 8'h07, 1, 1'b1, 2'b11, 1);
        exp_q.push_back(mk(2, 1'b0, 1'b1, 8'h07));
        drain("o1_bad");

        // Stop bits
        send_frame(3, 8'h3C, 0, 1'b0, 2'b01, 2);
        exp_q.push_back(mk(3, 1'b1, 1'b0, 8'h3C));
        drain("n2_stop2_low");
        send_frame(3, 8'hC3, 0, 1'b0, 2'b11, 2);
        exp_q.push_back(mk(3, 1'b0, 1'b0, 8'hC3));
        drain("n2_clean");
        send_frame(0, 8'h5A, 0, 1'b0, 2'b00, 1);
        exp_q.push_back(mk(0, 1'b1, 1'b0, 8'h5A));
        drain("n1_stop_low");
        idle(10);

        // Glitch reject: 4-cycle low pulse, START lasts CYC_HALF cycles
        b0 = busy_cnt[0];
        din_v[0] = 1'b0;
        idle(4);
        din_v[0] = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_fell", busy_w[0], 0);
        check("glitch_busy_cycles", busy_cnt[0] - b0, 8);
        idle(40);
        check("glitch_no_push", got_q.size(), rd_ptr);

        // Overrun on the fifth word with the consumer stalled
        rd_ready_v[0] = 1'b0;
        o0 = ov_cnt[0];
        for (int f = 1; f <= 4; f++) send_frame(0, 8'(f), 0, 1'b0, 2'b11, 1);
        idle(10);
        check("ov_none_at_4", ov_cnt[0] - o0, 0);
        send_frame(0, 8'h05, 0, 1'b0, 2'b11, 1);
        idle(10);
        check("ov_pulse_at_5", ov_cnt[0] - o0, 1);
        check("ov_valid", rd_valid_w[0], 1);
        check("ov_head_held", rd_data_w[0], 8'h01);
        rd_ready_v[0] = 1'b1;
        for (int f = 1; f <= 4; f++) exp_q.push_back(mk(0, 1'b0, 1'b0, 8'(f)));
        drain("ov_drain");
        idle(10);
        check("ov_no_fifth", got_q.size(), rd_ptr);

        // Reset mid-frame with the line held low through reset
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        din_v[0] = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy_w[0], 0);
        check("mid_rst_valid", rd_valid_w[0], 0);
        check("mid_rst_data", rd_data_w[0], 0);
        b0 = busy_cnt[0];
        idle(40);
        check("low_hold_no_start", busy_cnt[0] - b0, 0);
        check("low_hold_no_push", got_q.size(), rd_ptr);
        din_v[0] = 1'b1;
        idle(20);
        send_frame(0, 8'h55, 0, 1'b0, 2'b11, 1);
        exp_q.push_back(mk(0, 1'b0, 1'b0, 8'h55));
        drain("post_rst_55");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
